// File: rtl/pll_lock_supervisor.sv
// Reference-clock supervisor for the board PLL: pulses PLL reset, waits for a stable
// lock, and only then releases the design-wide reset. Single clock domain.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_reset,
    output logic             ready,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_lost_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int TMR_W   = $clog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] T_RST_END    = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_LOCK_END   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] T_STABLE_END = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] T_HOLD_END   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_pll_rst;
    logic                   r_sys_reset;
    logic                   r_ready;
    logic [CNT_W-1:0]       r_retry_cnt;
    logic [CNT_W-1:0]       r_lost_cnt;
    logic                   w_retry_evt;
    logic                   w_lost_evt;

    // LOCK is asynchronous; only the last synchroniser flop feeds the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_next      = r_state;
        w_retry_evt = 1'b0;
        w_lost_evt  = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_timer == T_RST_END) w_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next = S_STABLE;
                end else if (r_timer == T_LOCK_END) begin
                    w_next      = S_PLL_RST;
                    w_retry_evt = 1'b1;
                end
            end
            S_STABLE: begin
                // A dropout here is treated as a glitch: back to waiting, no PLL reset.
                if (!w_locked_s) begin
                    w_next = S_WAIT_LOCK;
                end else if (r_timer == T_STABLE_END) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_locked_s) begin
                    w_next     = S_PLL_RST;
                    w_lost_evt = 1'b1;
                end else if (r_timer == T_HOLD_END) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (!w_locked_s) begin
                    w_next     = S_PLL_RST;
                    w_lost_evt = 1'b1;
                end
            end
            default: w_next = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_PLL_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Timer restarts on every state change; RUN has no timeout so it parks there.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_next != r_state) begin
            r_timer <= '0;
        end else if (r_state != S_RUN) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_pll_rst   <= (w_next == S_PLL_RST);
            r_sys_reset <= (w_next != S_RUN);
            r_ready     <= (w_next == S_RUN);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retry_cnt <= '0;
            r_lost_cnt  <= '0;
        end else begin
            if (w_retry_evt && (r_retry_cnt != CNT_MAX)) r_retry_cnt <= r_retry_cnt + 1'b1;
            if (w_lost_evt && (r_lost_cnt != CNT_MAX)) r_lost_cnt <= r_lost_cnt + 1'b1;
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_reset       = r_sys_reset;
    assign ready           = r_ready;
    assign state           = r_state;
    assign retry_count     = r_retry_cnt;
    assign lock_lost_count = r_lost_cnt;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues expected output changes
// with their edge numbers; a negedge monitor pops and compares on every output change.
module tb_pll_lock_supervisor;

    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             pll_locked = 1'b0;
    logic             pll_rst;
    logic             sys_reset;
    logic             ready;
    logic [2:0]       state;
    logic [CNT_W-1:0] retry_count;
    logic [CNT_W-1:0] lock_lost_count;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (5),
        .CNT_W         (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .state          (state),
        .retry_count    (retry_count),
        .lock_lost_count(lock_lost_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] st;
        logic       prst;
        logic       srst;
        logic       rdy;
        logic [1:0] rc;
        logic [1:0] lc;
    } ev_t;

    ev_t  q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    logic [9:0] prev_bundle;

    function automatic logic [9:0] bundle();
        return {state, pll_rst, sys_reset, ready, retry_count, lock_lost_count};
    endfunction

    task automatic push(input int at, input logic [2:0] st, input logic [1:0] rc, input logic [1:0] lc);
        ev_t e;
        e.at   = at;
        e.st   = st;
        e.prst = (st == 3'd0);
        e.srst = (st != 3'd4);
        e.rdy  = (st == 3'd4);
        e.rc   = rc;
        e.lc   = lc;
        q.push_back(e);
    endtask

    // Lock observed after pin rises at edge t: STABLE +3, HOLD +11, RUN +16.
    task automatic lock_seq(input int t, input logic [1:0] rc, input logic [1:0] lc);
        push(t + 3, 3'd2, rc, lc);
        push(t + 11, 3'd3, rc, lc);
        push(t + 16, 3'd4, rc, lc);
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: expected change at edge %0d to state %0d not seen (edge %0d, state %0d)",
                         q[0].at, q[0].st, cyc, state);
                void'(q.pop_front());
            end
            if (bundle() != prev_bundle) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change at edge %0d: state=%0d pll_rst=%0b sys_reset=%0b ready=%0b rc=%0d lc=%0d",
                             cyc, state, pll_rst, sys_reset, ready, retry_count, lock_lost_count);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.at != cyc || e.st != state || e.prst != pll_rst || e.srst != sys_reset ||
                        e.rdy != ready || e.rc != retry_count || e.lc != lock_lost_count) begin
                        n_fail++;
                        $display("FAIL event: got edge=%0d st=%0d prst=%0b srst=%0b rdy=%0b rc=%0d lc=%0d, expected edge=%0d st=%0d prst=%0b srst=%0b rdy=%0b rc=%0d lc=%0d",
                                 cyc, state, pll_rst, sys_reset, ready, retry_count, lock_lost_count,
                                 e.at, e.st, e.prst, e.srst, e.rdy, e.rc, e.lc);
                    end
                end
                prev_bundle = bundle();
            end
        end
    end

    initial begin
        // Reset held for edges 1..3
        goto(3);
        chk("rst_state", int'(state), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_reset", int'(sys_reset), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_retry", int'(retry_count), 0);
        chk("rst_lost", int'(lock_lost_count), 0);
        prev_bundle = bundle();
        mon_en = 1'b1;
        reset  = 1'b0;
        push(7, 3'd1, 2'd0, 2'd0);

        // Test 1: lock from cycle 10 after reset release
        goto(13);
        pll_locked = 1'b1;
        lock_seq(13, 2'd0, 2'd0);
        goto(30);
        chk("t1_ready", int'(ready), 1);
        chk("t1_sys_reset", int'(sys_reset), 0);
        chk("t1_counters", int'({retry_count, lock_lost_count}), 0);

        // Test 4: lock loss in RUN, then full relock
        goto(35);
        pll_locked = 1'b0;
        push(38, 3'd0, 2'd0, 2'd1);
        push(42, 3'd1, 2'd0, 2'd1);
        goto(45);
        pll_locked = 1'b1;
        push(48, 3'd2, 2'd0, 2'd1);
        push(56, 3'd3, 2'd0, 2'd1);

        // Test 5: lock loss in HOLD
        goto(56);
        pll_locked = 1'b0;
        push(59, 3'd0, 2'd0, 2'd2);
        push(63, 3'd1, 2'd0, 2'd2);
        goto(64);
        chk("t5_sys_reset_held", int'(sys_reset), 1);
        pll_locked = 1'b1;
        push(67, 3'd2, 2'd0, 2'd2);
        push(75, 3'd3, 2'd0, 2'd2);

        // Test 6: one-cycle reset in HOLD with lock_lost_count=2
        goto(77);
        chk("t6_pre_lost", int'(lock_lost_count), 2);
        reset = 1'b1;
        push(78, 3'd0, 2'd0, 2'd0);
        goto(78);
        reset = 1'b0;
        chk("t6_state", int'(state), 0);
        chk("t6_pll_rst", int'(pll_rst), 1);
        chk("t6_sys_reset", int'(sys_reset), 1);
        chk("t6_lost", int'(lock_lost_count), 0);

        // Test 2: no lock, five timeouts, retry_count saturates at 3
        goto(79);
        pll_locked = 1'b0;
        push(82, 3'd1, 2'd0, 2'd0);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] rc;
            rc = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            push(82 + 24 * k + 20, 3'd0, rc, 2'd0);
            push(82 + 24 * k + 24, 3'd1, rc, 2'd0);
        end

        // Test 3: 3-cycle dropout during STABLE
        goto(205);
        chk("t2_retry_sat", int'(retry_count), 3);
        pll_locked = 1'b1;
        push(208, 3'd2, 2'd3, 2'd0);
        goto(210);
        pll_locked = 1'b0;
        push(213, 3'd1, 2'd3, 2'd0);
        goto(213);
        pll_locked = 1'b1;
        lock_seq(213, 2'd3, 2'd0);

        goto(235);
        chk("final_ready", int'(ready), 1);
        chk("final_counters", int'({retry_count, lock_lost_count}), 12);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
